// File: rtl/keyboard_scan.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces the first
// low row it sees, latches one key code and exposes key/status registers.
module keyboard_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic        kb_cs,
  input  logic        kb_read,
  input  logic [1:0]  kb_addr,
  output logic [15:0] kb_rdata
);

  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  // One spare bit so the incremented count can always hold DEBOUNCE_CNT.
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 2);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       key_q, key_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic             tick;
  logic             commit;
  logic             rd_key;
  logic             any_low;
  logic             row_hit;
  logic [1:0]       first_row;
  logic [CNT_W-1:0] cnt_inc;

  assign tick    = (div_q == DIV_W'(SCAN_DIV - 1));
  assign any_low = ~&row_in;
  assign row_hit = ~row_in[row_q];
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign rd_key  = kb_cs & kb_read & (kb_addr == 2'd0);
  assign col_out = ~(4'b0001 << col_q);

  always_comb begin
    first_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_in[i]) first_row = i[1:0];
    end
  end

  always_comb begin
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    col_d   = col_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    commit  = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (any_low) begin
            row_d   = first_row;
            cnt_d   = CNT_W'(1);
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (row_hit) begin
            if (cnt_inc >= CNT_W'(DEBOUNCE_CNT)) begin
              commit  = 1'b1;
              state_d = ST_HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        ST_HOLD: begin
          // Release needs the same run of stable samples as a press.
          if (!row_hit) begin
            if (cnt_inc >= CNT_W'(DEBOUNCE_CNT)) begin
              state_d = ST_SCAN;
              cnt_d   = '0;
              col_d   = col_q + 2'd1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  // A commit on the same edge as a key read wins; the old key counts as consumed.
  always_comb begin
    key_d     = key_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (commit) begin
      key_d     = {row_q, col_q};
      valid_d   = 1'b1;
      overrun_d = valid_q & ~rd_key;
    end else if (rd_key) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_comb begin
    kb_rdata = 16'h0000;
    if (kb_cs && kb_read) begin
      case (kb_addr)
        2'd0:    kb_rdata = {12'h000, key_q};
        2'd2:    kb_rdata = {14'h0000, overrun_q, valid_q};
        default: kb_rdata = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      col_q     <= 2'd0;
      state_q   <= ST_SCAN;
      cnt_q     <= '0;
      row_q     <= 2'd0;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      col_q     <= col_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
